// File: rtl/stack_seq_pkg.sv
// Shared types for the stack sequencer: data width, opcode and FSM enums,
// and the instruction payload.
package stack_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_AND  = 3'd5,
    OP_OR   = 3'd6,
    OP_DUP  = 3'd7
  } stack_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP_A  = 3'd1,
    ST_POP_B  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_PUSH_R = 3'd4
  } stack_seq_state_e;

  typedef struct packed {
    stack_op_e         op;
    logic [DATA_W-1:0] imm;
  } stack_instr_t;

  function automatic logic is_binary(stack_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Instruction handshake plus stack-side strobes and status of the sequencer.
interface stack_seq_if #(parameter int unsigned DEPTH = 8);
  import stack_seq_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              instr_valid;
  stack_instr_t      instr;
  logic              instr_ready;
  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] stk_din;
  logic [DATA_W-1:0] stk_tos;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              err;
  logic [CNT_W-1:0]  depth;

  modport master (
    output instr_valid, instr, stk_tos,
    input  instr_ready, stk_push, stk_pop, stk_din, result, result_valid, err, depth
  );

  modport slave (
    input  instr_valid, instr, stk_tos,
    output instr_ready, stk_push, stk_pop, stk_din, result, result_valid, err, depth
  );

endinterface

// File: rtl/stack_seq_alu.sv
// Combinational ALU for binary stack ops; B is the deeper operand, A the top.
module stack_seq_alu
  import stack_seq_pkg::*;
(
  input  stack_op_e         op,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] res_c
);

  always_comb begin
    res_c = '0;
    case (op)
      OP_ADD:  res_c = b + a;
      OP_SUB:  res_c = b - a;
      OP_AND:  res_c = b & a;
      OP_OR:   res_c = b | a;
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/stack_seq.sv
// Stack instruction sequencer: expands one instruction into push/pop strobes.
// Define STACK_SEQ_DEPTH_CHECK_EN to reject under/overflowing instructions.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  stack_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  stack_seq_state_e  state_q, state_d;
  stack_op_e         op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] stk_din_q, stk_din_d, result_q, result_d;
  logic              push_q, push_d, pop_q, pop_d;
  logic              result_valid_q, result_valid_d, err_q, err_d;
  logic              instr_ready_q, instr_ready_d;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic [DATA_W-1:0] alu_res_c;
  logic              reject_c;
  logic              accept_c;

  stack_seq_alu u_alu (
    .op    (op_q),
    .b     (b_q),
    .a     (a_q),
    .res_c (alu_res_c)
  );

`ifdef STACK_SEQ_DEPTH_CHECK_EN
  always_comb begin
    reject_c = 1'b0;
    case (bus.instr.op)
      OP_PUSH: reject_c = (depth_q == CNT_W'(DEPTH));
      OP_POP:  reject_c = (depth_q == '0);
      OP_DUP:  reject_c = (depth_q == '0) || (depth_q == CNT_W'(DEPTH));
      OP_ADD, OP_SUB, OP_AND, OP_OR: reject_c = (depth_q < CNT_W'(2));
      default: reject_c = 1'b0;
    endcase
  end
`else
  assign reject_c = 1'b0;
`endif

  // Strobes and result are looked ahead from state_d so they register into the cycle they describe.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    stk_din_d      = stk_din_q;
    result_d       = result_q;
    push_d         = 1'b0;
    pop_d          = 1'b0;
    result_valid_d = 1'b0;
    err_d          = 1'b0;
    depth_d        = depth_q;
    accept_c       = bus.instr_valid && instr_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (reject_c) begin
            err_d = 1'b1;
          end else begin
            case (bus.instr.op)
              OP_PUSH: begin
                stk_din_d = bus.instr.imm;
                state_d   = ST_PUSH_R;
              end
              OP_DUP: begin
                stk_din_d = bus.stk_tos;
                state_d   = ST_PUSH_R;
              end
              OP_POP: begin
                result_d       = bus.stk_tos;
                result_valid_d = 1'b1;
                pop_d          = 1'b1;
              end
              default: begin
                if (is_binary(bus.instr.op)) begin
                  op_d    = bus.instr.op;
                  state_d = ST_POP_A;
                end
              end
            endcase
          end
        end
      end
      ST_POP_A: begin
        a_d     = bus.stk_tos;
        state_d = ST_POP_B;
      end
      ST_POP_B: begin
        b_d     = bus.stk_tos;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        stk_din_d = alu_res_c;
        state_d   = ST_PUSH_R;
      end
      ST_PUSH_R: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (state_d == ST_PUSH_R) begin
      push_d         = 1'b1;
      result_d       = stk_din_d;
      result_valid_d = 1'b1;
    end
    if ((state_d == ST_POP_A) || (state_d == ST_POP_B)) pop_d = 1'b1;

    // Ready stays low during a POP strobe so the stack can present the new top.
    instr_ready_d = (state_d == ST_IDLE) && !pop_d;

    if (push_d) begin
      depth_d = (depth_q == CNT_W'(DEPTH)) ? '0 : depth_q + CNT_W'(1);
    end else if (pop_d) begin
      depth_d = (depth_q == '0) ? CNT_W'(DEPTH) : depth_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_NOP;
      a_q            <= '0;
      b_q            <= '0;
      stk_din_q      <= '0;
      result_q       <= '0;
      push_q         <= 1'b0;
      pop_q          <= 1'b0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      instr_ready_q  <= 1'b1;
      depth_q        <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      stk_din_q      <= stk_din_d;
      result_q       <= result_d;
      push_q         <= push_d;
      pop_q          <= pop_d;
      result_valid_q <= result_valid_d;
      err_q          <= err_d;
      instr_ready_q  <= instr_ready_d;
      depth_q        <= depth_d;
    end
  end

  assign bus.instr_ready  = instr_ready_q;
  assign bus.stk_push     = push_q;
  assign bus.stk_pop      = pop_q;
  assign bus.stk_din      = stk_din_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.err          = err_q;
  assign bus.depth        = depth_q;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq with a behavioural stack and a result scoreboard.
module tb_stack_seq;
  import stack_seq_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_push, n_pop;

  logic [7:0] ref_stk[$];
  logic [7:0] exp_q[$];

  stack_seq_if #(.DEPTH(DEPTH)) bus ();

  stack_seq #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 8-entry stack with a combinational top-of-stack.
  logic [7:0] mem [DEPTH];
  int sp;
  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (bus.stk_push && sp < int'(DEPTH)) begin
      mem[sp] <= bus.stk_din;
      sp      <= sp + 1;
    end else if (bus.stk_pop && sp > 0) sp <= sp - 1;
  end
  assign bus.stk_tos = (sp == 0) ? 8'd0 : mem[sp-1];

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit legal(stack_op_e op, int d);
    case (op)
      OP_PUSH: return d != int'(DEPTH);
      OP_POP:  return d != 0;
      OP_DUP:  return (d != 0) && (d != int'(DEPTH));
      OP_ADD, OP_SUB, OP_AND, OP_OR: return d >= 2;
      default: return 1'b1;
    endcase
  endfunction

  task automatic observe();
    logic [7:0] e;
    chk("push_pop_exclusive", 32'(bus.stk_push & bus.stk_pop), 0);
    if (bus.stk_push) n_push++;
    if (bus.stk_pop)  n_pop++;
    if (bus.result_valid) begin
      if (exp_q.size() == 0) chk("unexpected_result_valid", 32'(bus.result_valid), 0);
      else begin
        e = exp_q.pop_front();
        chk("result", 32'(bus.result), 32'(e));
        if (bus.stk_push) chk("stk_din", 32'(bus.stk_din), 32'(e));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_stk.delete();
    exp_q.delete();
  endtask

  // Issue one instruction, predict its effect and check everything until ready returns.
  task automatic exec(input stack_op_e op, input logic [7:0] imm);
    logic       rej;
    logic [7:0] a, b, r;
    int exp_push, exp_pop, exp_busy, busy;
    rej = 1'b0;
`ifdef STACK_SEQ_DEPTH_CHECK_EN
    rej = !legal(op, ref_stk.size());
`endif
    exp_push = 0; exp_pop = 0; exp_busy = 0; r = '0;
    if (!rej) begin
      case (op)
        OP_PUSH: begin r = imm; exp_push = 1; exp_busy = 1; end
        OP_DUP:  begin r = ref_stk[$]; exp_push = 1; exp_busy = 1; end
        OP_POP:  begin r = ref_stk.pop_back(); exp_pop = 1; exp_busy = 1; end
        OP_NOP:  ;
        default: begin
          a = ref_stk.pop_back();
          b = ref_stk.pop_back();
          case (op)
            OP_ADD:  r = b + a;
            OP_SUB:  r = b - a;
            OP_AND:  r = b & a;
            default: r = b | a;
          endcase
          exp_push = 1; exp_pop = 2; exp_busy = 4;
        end
      endcase
      if (exp_push == 1) ref_stk.push_back(r);
      if (op != OP_NOP) exp_q.push_back(r);
    end
    chk("ready_before_issue", 32'(bus.instr_ready), 1);
    bus.instr_valid = 1'b1;
    bus.instr.op    = op;
    bus.instr.imm   = imm;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("err_on_accept", 32'(bus.err), 32'(rej));
    busy = 0; n_push = 0; n_pop = 0;
    forever begin
      observe();
      if (bus.instr_ready || busy >= 20) break;
      @(negedge clk);
      busy++;
    end
    chk("busy_cycles", busy, exp_busy);
    chk("push_count", n_push, exp_push);
    chk("pop_count", n_pop, exp_pop);
    chk("depth", 32'(bus.depth), ref_stk.size());
    chk("scoreboard_drained", exp_q.size(), 0);
    if (busy == 0) @(negedge clk);
    chk("err_single_pulse", 32'(bus.err), 0);
  endtask

  initial begin
    stack_op_e op;
    do_reset();

    // Reset state
    chk("rst_ready", 32'(bus.instr_ready), 1);
    chk("rst_push", 32'(bus.stk_push), 0);
    chk("rst_pop", 32'(bus.stk_pop), 0);
    chk("rst_din", 32'(bus.stk_din), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_result_valid", 32'(bus.result_valid), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_depth", 32'(bus.depth), 0);

    // POP on an empty stack
`ifdef STACK_SEQ_DEPTH_CHECK_EN
    exec(OP_POP, 8'd0);
`else
    bus.instr_valid = 1'b1;
    bus.instr.op    = OP_POP;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("nochk_underflow_err", 32'(bus.err), 0);
    chk("nochk_underflow_pop", 32'(bus.stk_pop), 1);
    @(negedge clk);
    chk("nochk_depth_wrap", 32'(bus.depth), DEPTH);
`endif

    // 5 - 3
    do_reset();
    exec(OP_PUSH, 8'd5);
    exec(OP_PUSH, 8'd3);
    exec(OP_SUB, 8'd0);
    chk("sub_depth", 32'(bus.depth), 1);

    // 200 + 100 wraps to 44, then DUP/AND keeps 44
    do_reset();
    exec(OP_PUSH, 8'd200);
    exec(OP_PUSH, 8'd100);
    exec(OP_ADD, 8'd0);
    chk("add_wrap_result", 32'(bus.result), 44);
    exec(OP_DUP, 8'd0);
    exec(OP_AND, 8'd0);
    chk("and_result", 32'(bus.result), 44);
    chk("and_depth", 32'(bus.depth), 1);
    exec(OP_POP, 8'd0);

    // Fill to capacity; overflowing PUSH rejected, binary op at full is legal
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) exec(OP_PUSH, 8'($urandom_range(0, 255)));
`ifdef STACK_SEQ_DEPTH_CHECK_EN
    exec(OP_PUSH, 8'd1);
    exec(OP_DUP, 8'd0);
`endif
    exec(OP_OR, 8'd0);
    chk("or_at_full_depth", 32'(bus.depth), 7);

    // Reset during POP_B of an ADD
    do_reset();
    exec(OP_PUSH, 8'd1);
    exec(OP_PUSH, 8'd2);
    bus.instr_valid = 1'b1;
    bus.instr.op    = OP_ADD;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("abort_pop_a", 32'(bus.stk_pop), 1);
    @(negedge clk);
    chk("abort_pop_b", 32'(bus.stk_pop), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_stk.delete();
    chk("abort_ready", 32'(bus.instr_ready), 1);
    chk("abort_depth", 32'(bus.depth), 0);
    chk("abort_result", 32'(bus.result), 0);
    repeat (3) begin
      chk("abort_no_push", 32'(bus.stk_push), 0);
      chk("abort_no_pop", 32'(bus.stk_pop), 0);
      chk("abort_no_valid", 32'(bus.result_valid), 0);
      @(negedge clk);
    end

    // NOP held valid for three cycles
    bus.instr_valid = 1'b1;
    bus.instr.op    = OP_NOP;
    repeat (3) begin
      @(negedge clk);
      chk("nop_ready", 32'(bus.instr_ready), 1);
      chk("nop_push", 32'(bus.stk_push), 0);
      chk("nop_pop", 32'(bus.stk_pop), 0);
      chk("nop_valid", 32'(bus.result_valid), 0);
    end
    bus.instr_valid = 1'b0;
    @(negedge clk);

    // Random mix of instructions against the reference stack
    do_reset();
    for (int i = 0; i < 40; i++) begin
      op = stack_op_e'($urandom_range(0, 7));
`ifndef STACK_SEQ_DEPTH_CHECK_EN
      if (!legal(op, ref_stk.size())) op = OP_NOP;
`endif
      exec(op, 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
